multi_pulse_gen: RTL and testbench
==================================

# multi_pulse_gen

Parametrised, multi-channel successor to the single-switch pulse generator. It produces one SYNC marker per period and NCH independent gated pulse trains. Each channel has its own delay, its own width, and a CPMG-style repetition count. Parameters are double-buffered: a host-side load strobe (UART control decoder `rxd`) is applied only on a period boundary, so no period is ever emitted with mixed settings. The block sits between the serial control decoder and the output pins, in the PLL clock domain.

## Interface
- NCH, 4, number of pulse channels
- PER_W, 24, period counter width
- T_W, 16, delay/width/spacing field width
- REP_W, 8, repetition count width
- SYNC_W, 8, SYNC pulse length in cycles (≥1)
- clk  in  1  PLL clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run when high; halt and clear outputs when low
- load  in  1  one-cycle strobe; captures all parameter inputs into shadow registers
- per  in  PER_W  period in cycles
- del  in  NCH*T_W  per-channel delay from period start; channel i is bits [i*T_W +: T_W]
- wid  in  NCH*T_W  per-channel pulse width
- rep  in  NCH*REP_W  per-channel extra repetitions (0 = single pulse)
- sp  in  NCH*T_W  per-channel start-to-start repetition spacing
- sync_on  out  1  period marker
- pulse_on  out  NCH  channel outputs
- load_ack  out  1  one-cycle pulse when shadow values become active
- busy  out  1  high while a period is running

## Operation
- Registers: shadow set (written on load), active set (used for generation), period counter t, pending flag.
- load: captures all inputs into the shadow set and sets pending. If several loads arrive before a boundary, the last one wins.
- Transfer shadow → active, clear pending, and pulse load_ack for 1 cycle when pending is set and any of the following holds:
  - t = per−1 (wrap);
  - enable is low;
  - active per < 2.
- load and transfer in the same cycle: the new load is captured into the shadow set and pending remains set.
- Halted state: active per < 2 or enable low. In this state t is held at 0; sync_on, pulse_on and busy are 0.
- Running state: t counts 0…per−1 and wraps. busy = 1.
- sync_on is 1 for t < min(SYNC_W, per).
- Channel i, with base start s_k = del + k·sp for k = 0…rep:
  - pulse_on[i] = 1 when s_k ≤ t < s_k + wid for any k.
  - The channel is implemented as a per-channel FSM with states WAIT, HIGH, GAP, DONE and a down-counter, not a comparator bank.
  - FSM transitions:
    - WAIT → HIGH when t = del.
    - HIGH → GAP after wid cycles, or → DONE if the last repetition is complete.
    - GAP → HIGH after sp − wid cycles.
    - If sp ≤ wid, HIGH continues without a gap; the output is the union of the windows.
  - Every channel FSM returns to WAIT at each wrap.
- Boundary conditions:
  - wid = 0: the channel never goes high.
  - A pulse extending past per−1 is truncated at the wrap and does not carry over.
  - del ≥ per: the channel stays low.
- Arithmetic: s_k + wid is computed at PER_W+1 bits, so there is no overflow aliasing.
- reset: zeroes the active set, shadow set, pending flag, t and all FSMs. All outputs read 0 in the cycle after reset is sampled, including when reset is asserted mid-period.

## Timing
- Outputs are registered.
- enable or transfer sampled at edge k → the output for t = 0 appears after edge k+1.
- Period start to period start is exactly per cycles.
- sync_on rises in the same cycle as the t = 0 output. pulse_on[i] rises del cycles later.
- load_ack coincides with the first output cycle (t = 0) of the new settings.
- Latency from load to effect: at most per+1 cycles while running; 2 cycles while halted.
- All reset values are 0: sync_on, pulse_on, load_ack, busy.

## Test plan
- Single pulse, channel 0: per=100, del=10, wid=5, rep=0, then enable → sync_on high at t=0..7; pulse_on[0] high at t=10..14; pattern repeats every 100 cycles.
- CPMG, channel 1: del=20, wid=4, sp=10, rep=3 → pulses at t=20, 30, 40, 50, each 4 cycles wide; nothing after t=53.
- Merge and truncation: wid=8, sp=5, rep=2, del=90, per=100 → continuous high from t=90 to t=99; low at the next t=0.
- Double-buffering: load new del while running at t=40 → the current period is unchanged; load_ack fires at the next t=0 and the new del applies from that period. Two loads in one period → only the second takes effect.
- Degenerate values: per=1, wid=0, or del ≥ per → outputs stay low as specified; busy=0 when per=1.
- Reset at t=37 with channels high → all outputs 0 the next cycle; nothing runs until a new load and enable.

Source files
------------

// File: rtl/multi_pulse_gen_if.sv
// multi_pulse_gen_if
// Groups the host-side parameter/load bus and the generated outputs of
// multi_pulse_gen.
//   enable    run when high
//   load      one-cycle strobe capturing per/del/wid/rep/sp into the shadow set
//   per       period in cycles
//   del/wid/sp per-channel delay, width, start-to-start spacing (T_W each)
//   rep       per-channel extra repetitions (REP_W each)
//   sync_on   period marker
//   pulse_on  channel outputs
//   load_ack  one-cycle pulse when shadow values become active
//   busy      high while a period is running
interface multi_pulse_gen_if #(
    parameter int NCH   = 4,
    parameter int PER_W = 24,
    parameter int T_W   = 16,
    parameter int REP_W = 8
);
    logic                   enable;
    logic                   load;
    logic [PER_W-1:0]       per;
    logic [NCH*T_W-1:0]     del;
    logic [NCH*T_W-1:0]     wid;
    logic [NCH*REP_W-1:0]   rep;
    logic [NCH*T_W-1:0]     sp;
    logic                   sync_on;
    logic [NCH-1:0]         pulse_on;
    logic                   load_ack;
    logic                   busy;

    modport master (
        output enable, load, per, del, wid, rep, sp,
        input  sync_on, pulse_on, load_ack, busy
    );

    modport slave (
        input  enable, load, per, del, wid, rep, sp,
        output sync_on, pulse_on, load_ack, busy
    );
endinterface

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen
// One SYNC marker per period plus NCH gated pulse trains, each with its own
// delay, width, repetition count and spacing. Parameters are double-buffered
// (shadow -> active) and swapped only on a period boundary or while halted.
//   clk    PLL clock, rising edge
//   reset  synchronous, active-high
//   bus    multi_pulse_gen_if.slave (parameters in, pulses/status out)

// Per-channel generator. Its state describes the current value of t; hi is the
// combinational output for that t and is registered by the top level.
module mpg_channel #(
    parameter int PER_W = 24,
    parameter int T_W   = 16,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,   // halted or wrapping: back to WAIT
    input  logic             adv,       // running: advance one t step
    input  logic [PER_W-1:0] t,
    input  logic [T_W-1:0]   del,
    input  logic [T_W-1:0]   wid,
    input  logic [T_W-1:0]   sp,
    input  logic [REP_W-1:0] rep,
    output logic             hi
);
    typedef enum logic [1:0] {ST_WAIT, ST_HIGH, ST_GAP, ST_DONE} ch_state_t;

    ch_state_t        state, state_n;
    logic [T_W-1:0]   wcnt, wcnt_n;     // high cycles left, counting this one
    logic [T_W-1:0]   scnt, scnt_n;     // cycles until the next window start
    logic [REP_W-1:0] rleft, rleft_n;   // window starts still to come
    logic [T_W-1:0]   w_eff;
    logic             start;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state <= ST_WAIT;
            wcnt  <= '0;
            scnt  <= '0;
            rleft <= '0;
        end else if (adv) begin
            state <= state_n;
            wcnt  <= wcnt_n;
            scnt  <= scnt_n;
            rleft <= rleft_n;
        end
    end

    always_comb begin
        start   = 1'b0;
        state_n = state;
        rleft_n = rleft;
        scnt_n  = (scnt != '0) ? scnt - T_W'(1) : '0;

        if (state == ST_WAIT)
            start = ({{T_W{1'b0}}, t} == {{PER_W{1'b0}}, del});
        else if (state != ST_DONE)
            start = (scnt == '0) && (rleft != '0);

        // Overlapping windows (sp <= wid) merge: keep the later end.
        w_eff = wcnt;
        if (start && (wid > wcnt))
            w_eff = wid;
        hi     = (w_eff != '0);
        wcnt_n = hi ? w_eff - T_W'(1) : '0;

        if (start) begin
            rleft_n = (state == ST_WAIT) ? rep : rleft - REP_W'(1);
            scnt_n  = sp - T_W'(1);
            // Zero spacing puts every repetition on the same start.
            if (sp == '0)
                rleft_n = '0;
        end

        if (state == ST_DONE || (state == ST_WAIT && !start))
            state_n = state;
        else if (wcnt_n != '0)
            state_n = ST_HIGH;
        else if (rleft_n != '0)
            state_n = ST_GAP;
        else
            state_n = ST_DONE;
    end
endmodule

module multi_pulse_gen #(
    parameter int NCH    = 4,
    parameter int PER_W  = 24,
    parameter int T_W    = 16,
    parameter int REP_W  = 8,
    parameter int SYNC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    multi_pulse_gen_if.slave   bus
);
    logic [PER_W-1:0]     sh_per, act_per;
    logic [NCH*T_W-1:0]   sh_del, sh_wid, sh_sp, act_del, act_wid, act_sp;
    logic [NCH*REP_W-1:0] sh_rep, act_rep;
    logic                 pend, run, xfer_q;
    logic [PER_W-1:0]     t;
    logic                 halted, active, wrap, xfer;
    logic [NCH-1:0]       ch_hi;

    // run is set one cycle after leaving halt so the t = 0 output lands one
    // edge after enable/transfer is sampled.
    always_comb begin
        halted = !bus.enable || (act_per < PER_W'(2));
        active = run && !halted;
        wrap   = active && (t == act_per - PER_W'(1));
        xfer   = pend && (halted || wrap);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_per  <= '0; sh_del  <= '0; sh_wid  <= '0; sh_sp  <= '0; sh_rep  <= '0;
            act_per <= '0; act_del <= '0; act_wid <= '0; act_sp <= '0; act_rep <= '0;
            pend    <= 1'b0;
            run     <= 1'b0;
            t       <= '0;
            xfer_q  <= 1'b0;
            bus.sync_on  <= 1'b0;
            bus.pulse_on <= '0;
            bus.busy     <= 1'b0;
            bus.load_ack <= 1'b0;
        end else begin
            // A load coinciding with a transfer wins: pending stays set.
            if (bus.load) begin
                sh_per <= bus.per;
                sh_del <= bus.del;
                sh_wid <= bus.wid;
                sh_sp  <= bus.sp;
                sh_rep <= bus.rep;
                pend   <= 1'b1;
            end else if (xfer) begin
                pend   <= 1'b0;
            end
            if (xfer) begin
                act_per <= sh_per;
                act_del <= sh_del;
                act_wid <= sh_wid;
                act_sp  <= sh_sp;
                act_rep <= sh_rep;
            end
            run <= !halted;
            t   <= (active && !wrap) ? t + PER_W'(1) : '0;
            xfer_q <= xfer;
            // t < per always holds while running, so this is t < min(SYNC_W, per).
            bus.sync_on  <= active && (t < PER_W'(SYNC_W));
            bus.pulse_on <= active ? ch_hi : '0;
            bus.busy     <= active;
            bus.load_ack <= xfer_q;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mpg_channel #(.PER_W(PER_W), .T_W(T_W), .REP_W(REP_W)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .restart (!active || wrap),
            .adv     (active),
            .t       (t),
            .del     (act_del[i*T_W +: T_W]),
            .wid     (act_wid[i*T_W +: T_W]),
            .sp      (act_sp[i*T_W +: T_W]),
            .rep     (act_rep[i*REP_W +: REP_W]),
            .hi      (ch_hi[i])
        );
    end
endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed bench for multi_pulse_gen: single pulse, CPMG train, merge and
// truncation, double-buffered reload, mid-period reset, degenerate settings.
module tb_multi_pulse_gen;
    localparam int NCH = 4, PER_W = 24, T_W = 16, REP_W = 8, SYNC_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multi_pulse_gen_if #(.NCH(NCH), .PER_W(PER_W), .T_W(T_W), .REP_W(REP_W)) bus ();

    multi_pulse_gen #(.NCH(NCH), .PER_W(PER_W), .T_W(T_W), .REP_W(REP_W), .SYNC_W(SYNC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input int d, input int w, input int r, input int s);
        bus.del[i*T_W +: T_W]     = T_W'(d);
        bus.wid[i*T_W +: T_W]     = T_W'(w);
        bus.rep[i*REP_W +: REP_W] = REP_W'(r);
        bus.sp[i*T_W +: T_W]      = T_W'(s);
    endtask

    // Hand-derived windows for the main 100-cycle configuration.
    function automatic logic [3:0] exp_main(input int t, input int d0);
        logic [3:0] e;
        e[0] = (t >= d0) && (t < d0 + 5);
        e[1] = (t >= 20 && t < 24) || (t >= 30 && t < 34) ||
               (t >= 40 && t < 44) || (t >= 50 && t < 54);
        e[2] = (t >= 90);
        e[3] = 1'b0;
        return e;
    endfunction

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.per    = '0;
        bus.del    = '0;
        bus.wid    = '0;
        bus.rep    = '0;
        bus.sp     = '0;
        tick();
        tick();
        chk("rst_sync",  bus.sync_on, 0);
        chk("rst_pulse", bus.pulse_on, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_ack",   bus.load_ack, 0);
        reset = 1'b0;

        // Load while halted: transfer next edge, ack the edge after.
        bus.per = 100;
        set_ch(0, 10, 5, 0, 0);
        set_ch(1, 20, 4, 3, 10);
        set_ch(2, 90, 8, 2, 5);
        set_ch(3, 5, 0, 0, 0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        chk("ack_early", bus.load_ack, 0);
        tick();
        chk("ack_halted", bus.load_ack, 1);
        chk("busy_halted", bus.busy, 0);

        bus.enable = 1'b1;
        tick();
        chk("busy_pre_run", bus.busy, 0);
        chk("sync_pre_run", bus.sync_on, 0);

        // Four periods; reloads of ch0 del at t=40 (30) and t=50 (60) of the
        // third period: only the second one applies, from the fourth period.
        for (int i = 0; i < 400; i++) begin
            int t, d0;
            tick();
            t  = i % 100;
            d0 = (i >= 300) ? 60 : 10;
            chk("sync",  bus.sync_on, (t < 8));
            chk("pulse", bus.pulse_on, exp_main(t, d0));
            chk("busy",  bus.busy, 1);
            chk("ack",   bus.load_ack, (i == 300));
            if (i == 240) begin
                set_ch(0, 30, 5, 0, 0);
                bus.load = 1'b1;
            end else if (i == 250) begin
                set_ch(0, 60, 5, 0, 0);
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
        end

        // Mid-period reset while ch2 is high.
        for (int i = 0; i < 93; i++) tick();
        chk("pre_rst_pulse", bus.pulse_on, 4'b0100);
        chk("pre_rst_busy",  bus.busy, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_pulse", bus.pulse_on, 0);
        chk("mid_rst_sync",  bus.sync_on, 0);
        chk("mid_rst_busy",  bus.busy, 0);
        chk("mid_rst_ack",   bus.load_ack, 0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_busy",  bus.busy, 0);
        chk("post_rst_pulse", bus.pulse_on, 0);

        // per = 1 never runs.
        bus.per = 1;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        chk("per1_ack", bus.load_ack, 1);
        tick(); tick(); tick();
        chk("per1_busy",  bus.busy, 0);
        chk("per1_sync",  bus.sync_on, 0);
        chk("per1_pulse", bus.pulse_on, 0);

        // per = 50: del >= per, wid = 0, truncation at t=49, plain pulse.
        bus.per = 50;
        set_ch(0, 60, 5, 0, 0);
        set_ch(1, 0, 0, 0, 0);
        set_ch(2, 49, 4, 0, 0);
        set_ch(3, 10, 3, 0, 0);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        chk("p50_ack",  bus.load_ack, 1);
        chk("p50_busy", bus.busy, 0);
        for (int i = 0; i < 100; i++) begin
            int t;
            logic [3:0] e;
            tick();
            t = i % 50;
            e = {(t >= 10 && t < 13), (t == 49), 1'b0, 1'b0};
            chk("p50_sync",  bus.sync_on, (t < 8));
            chk("p50_pulse", bus.pulse_on, e);
            chk("p50_busy",  bus.busy, 1);
        end

        // Dropping enable halts and clears outputs.
        bus.enable = 1'b0;
        tick();
        chk("dis_busy",  bus.busy, 0);
        chk("dis_sync",  bus.sync_on, 0);
        chk("dis_pulse", bus.pulse_on, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
